// File: rtl/wb_csr_ctrl_pkg.sv
// Shared constants for the write-back CSR controller: CSR numbers,
// exception codes, exception-flag bit positions and redirect FSM states.
package wb_csr_ctrl_pkg;

  localparam logic [13:0] CSR_CRMD  = 14'h0000;
  localparam logic [13:0] CSR_SAVE0 = 14'h0030;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  // Bit positions inside ws_ex_flags = {ale, brk, sys, ine, adef}
  localparam int EXF_ADEF = 0;
  localparam int EXF_INE  = 1;
  localparam int EXF_SYS  = 2;
  localparam int EXF_BRK  = 3;
  localparam int EXF_ALE  = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_REDIR = 2'b01,
    ST_HOLD  = 2'b10
  } state_e;

  // csrxchg writes only the bits selected by rj; csrwr writes the whole register.
  function automatic logic [31:0] csr_wmask_sel(input logic [2:0] op, input logic [31:0] rj);
    return op[1] ? rj : 32'hFFFF_FFFF;
  endfunction

endpackage

// File: rtl/wb_csr_ctrl_ex_prio_enc.sv
// Fixed-priority exception encoder: picks the winning cause among a pending
// interrupt and the synchronous exception flags collected upstream.
module wb_csr_ctrl_ex_prio_enc
  import wb_csr_ctrl_pkg::*;
(
  input  logic       i_has_int,
  input  logic [4:0] i_ex_flags,
  output logic       o_valid,
  output logic [5:0] o_ecode,
  output logic [8:0] o_esubcode,
  output logic       o_use_badv
);

  // Interrupts outrank every synchronous cause; among those the earliest pipeline fault wins.
  always_comb begin
    o_valid    = 1'b1;
    o_ecode    = ECODE_INT;
    o_esubcode = '0;
    o_use_badv = 1'b0;
    if (i_has_int) begin
      o_ecode = ECODE_INT;
    end else if (i_ex_flags[EXF_ADEF]) begin
      o_ecode    = ECODE_ADEF;
      o_use_badv = 1'b1;
    end else if (i_ex_flags[EXF_INE]) begin
      o_ecode = ECODE_INE;
    end else if (i_ex_flags[EXF_SYS]) begin
      o_ecode = ECODE_SYS;
    end else if (i_ex_flags[EXF_BRK]) begin
      o_ecode = ECODE_BRK;
    end else if (i_ex_flags[EXF_ALE]) begin
      o_ecode    = ECODE_ALE;
      o_use_badv = 1'b1;
    end else begin
      o_valid = 1'b0;
    end
  end

endmodule

// File: rtl/wb_csr_ctrl.sv
// Write-back CSR controller: arbitrates CSR accesses, exceptions, interrupts
// and ERTN in WB, drives the CSR file ports, and runs the redirect FSM that
// flushes the pipeline and hands the new PC to fetch over valid/ready.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_RUN   | WB instructions accepted; an exception/ERTN starts a redirect
//   ST_REDIR | flush held, redirect offered to fetch until redir_ready
//   ST_HOLD  | flush held for FLUSH_HOLD extra cycles after the handshake
module wb_csr_ctrl
  import wb_csr_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_HOLD = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_valid,
  input  logic [31:0] ws_pc,
  input  logic [2:0]  ws_op,
  input  logic        ws_csr_rd,
  input  logic [13:0] ws_csr_num,
  input  logic [31:0] ws_rj_value,
  input  logic [31:0] ws_rd_value,
  input  logic [4:0]  ws_ex_flags,
  input  logic [31:0] ws_badv,
  input  logic        has_int,
  output logic        csr_re,
  output logic        csr_we,
  output logic [13:0] csr_num,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  input  logic [31:0] csr_rvalue,
  output logic        wb_ex,
  output logic        ertn_flush,
  output logic [31:0] wb_csr_pc,
  output logic [31:0] wb_vaddr,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  input  logic [31:0] ex_entry,
  input  logic [31:0] ertn_entry,
  output logic [31:0] ws_rf_wdata,
  output logic        ws_commit,
  output logic        flush_o,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  input  logic        redir_ready
);

  localparam logic [3:0] HOLD_INIT = 4'(FLUSH_HOLD);

  state_e      r_state;
  state_e      w_state_nxt;
  logic [3:0]  r_hold_cnt;
  logic        r_redir_valid;
  logic [31:0] r_redir_pc;

  logic        w_take;
  logic        w_exc;
  logic        w_ertn;
  logic        w_event;
  logic        w_handshake;
  logic        w_ex_valid;
  logic [5:0]  w_ex_ecode;
  logic [8:0]  w_ex_esubcode;
  logic        w_ex_use_badv;

  wb_csr_ctrl_ex_prio_enc u_prio (
    .i_has_int  (has_int),
    .i_ex_flags (ws_ex_flags),
    .o_valid    (w_ex_valid),
    .o_ecode    (w_ex_ecode),
    .o_esubcode (w_ex_esubcode),
    .o_use_badv (w_ex_use_badv)
  );

  // WB is only honoured in RUN; an interrupted instruction is squashed, never executed.
  assign w_take      = ws_valid & (r_state == ST_RUN);
  assign w_exc       = w_take & w_ex_valid;
  assign w_ertn      = w_take & ws_op[2] & ~w_exc;
  assign w_event     = w_exc | w_ertn;
  assign w_handshake = (r_state == ST_REDIR) & r_redir_valid & redir_ready;

  assign csr_re      = w_take & ws_csr_rd & ~w_exc;
  assign csr_we      = csr_re & (ws_op[0] | ws_op[1]);
  assign csr_num     = ws_csr_num;
  assign csr_wmask   = csr_wmask_sel(ws_op, ws_rj_value);
  assign csr_wvalue  = ws_rd_value;
  assign ws_rf_wdata = csr_rvalue;
  assign ws_commit   = w_take & ~w_exc;

  assign wb_ex       = w_exc;
  assign ertn_flush  = w_ertn;
  assign wb_csr_pc   = ws_pc;
  assign wb_vaddr    = (w_exc & w_ex_use_badv) ? ws_badv : 32'h0;
  assign wb_ecode    = w_ex_ecode;
  assign wb_esubcode = w_ex_esubcode;

  assign redir_valid = r_redir_valid;
  assign redir_pc    = r_redir_pc;

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: redirect on event, wait for fetch, optionally hold the flush.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_event) w_state_nxt = ST_REDIR;
      end
      ST_REDIR: begin
        if (w_handshake) w_state_nxt = (FLUSH_HOLD == 0) ? ST_RUN : ST_HOLD;
      end
      ST_HOLD: begin
        if (r_hold_cnt <= 4'd1) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Flush covers the event cycle itself plus every non-RUN cycle.
  always_comb begin
    flush_o = w_event | (r_state == ST_REDIR) | (r_state == ST_HOLD);
  end

  // Redirect request: valid exactly while the FSM sits in REDIR; target captured on the event.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_redir_valid <= 1'b0;
      r_redir_pc    <= 32'h0;
    end else begin
      r_redir_valid <= (w_state_nxt == ST_REDIR);
      if (w_event) r_redir_pc <= w_exc ? ex_entry : ertn_entry;
    end
  end

  // Hold down-counter: loaded at the handshake, counts down while in HOLD.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_hold_cnt <= 4'd0;
    end else if (w_handshake) begin
      r_hold_cnt <= HOLD_INIT;
    end else if ((r_state == ST_HOLD) && (r_hold_cnt != 4'd0)) begin
      r_hold_cnt <= r_hold_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_wb_csr_ctrl.sv
// Bench for wb_csr_ctrl: directed vectors with literal expectations plus a
// behavioural model checked against every output on every cycle.
module tb_wb_csr_ctrl;
  import wb_csr_ctrl_pkg::*;

  localparam int FH = 2;

  logic        clk;
  logic        resetn;
  logic        ws_valid;
  logic [31:0] ws_pc;
  logic [2:0]  ws_op;
  logic        ws_csr_rd;
  logic [13:0] ws_csr_num;
  logic [31:0] ws_rj_value;
  logic [31:0] ws_rd_value;
  logic [4:0]  ws_ex_flags;
  logic [31:0] ws_badv;
  logic        has_int;
  logic        csr_re;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic [31:0] csr_rvalue;
  logic        wb_ex;
  logic        ertn_flush;
  logic [31:0] wb_csr_pc;
  logic [31:0] wb_vaddr;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] ex_entry;
  logic [31:0] ertn_entry;
  logic [31:0] ws_rf_wdata;
  logic        ws_commit;
  logic        flush_o;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        redir_ready;

  wb_csr_ctrl #(.FLUSH_HOLD(FH)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .ws_valid    (ws_valid),
    .ws_pc       (ws_pc),
    .ws_op       (ws_op),
    .ws_csr_rd   (ws_csr_rd),
    .ws_csr_num  (ws_csr_num),
    .ws_rj_value (ws_rj_value),
    .ws_rd_value (ws_rd_value),
    .ws_ex_flags (ws_ex_flags),
    .ws_badv     (ws_badv),
    .has_int     (has_int),
    .csr_re      (csr_re),
    .csr_we      (csr_we),
    .csr_num     (csr_num),
    .csr_wmask   (csr_wmask),
    .csr_wvalue  (csr_wvalue),
    .csr_rvalue  (csr_rvalue),
    .wb_ex       (wb_ex),
    .ertn_flush  (ertn_flush),
    .wb_csr_pc   (wb_csr_pc),
    .wb_vaddr    (wb_vaddr),
    .wb_ecode    (wb_ecode),
    .wb_esubcode (wb_esubcode),
    .ex_entry    (ex_entry),
    .ertn_entry  (ertn_entry),
    .ws_rf_wdata (ws_rf_wdata),
    .ws_commit   (ws_commit),
    .flush_o     (flush_o),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .redir_ready (redir_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Attached CSR file: reads combinational, writes land at the clock edge.
  logic [31:0] csr_mem [64];
  logic        mem_init = 1'b0;
  logic        wr_pend  = 1'b0;
  logic [5:0]  wr_addr  = '0;
  logic [31:0] wr_data  = '0;

  assign csr_rvalue = csr_mem[ws_csr_num[5:0]];

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) csr_mem[i] <= 32'h0;
      csr_mem[CSR_CRMD[5:0]]  <= 32'h0000_0008;
      csr_mem[CSR_SAVE0[5:0]] <= 32'hAAAA_5555;
      mem_init <= 1'b1;
    end else if (wr_pend) begin
      csr_mem[wr_addr] <= wr_data;
    end
  end

  // Exception code for each flag bit; lower bit index = higher priority.
  logic [5:0] code_of_bit [5];
  initial begin
    code_of_bit[0] = 6'h08;
    code_of_bit[1] = 6'h0D;
    code_of_bit[2] = 6'h0B;
    code_of_bit[3] = 6'h0C;
    code_of_bit[4] = 6'h09;
  end

  // Model state: is a redirect still outstanding, flush cycles left after it, target.
  bit          m_known = 1'b0;
  bit          m_pend  = 1'b0;
  int          m_hold  = 0;
  logic [31:0] m_pc    = '0;

  bit          e_run, e_take, e_exc, e_ertn, e_re, e_we, e_flush, e_badv;
  logic [5:0]  e_code;
  logic [31:0] e_mask, e_old;

  always @(negedge clk) begin
    e_run  = !m_pend && (m_hold == 0);
    e_take = ws_valid && e_run;
    e_exc  = e_take && (has_int || (ws_ex_flags != 5'b0));
    e_code = 6'h00;
    e_badv = 1'b0;
    if (!has_int) begin
      for (int b = 4; b >= 0; b--) begin
        if (ws_ex_flags[b]) begin
          e_code = code_of_bit[b];
          e_badv = (b == 0) || (b == 4);
        end
      end
    end
    e_ertn  = e_take && ws_op[2] && !e_exc;
    e_re    = e_take && ws_csr_rd && !e_exc;
    e_we    = e_re && (ws_op[1] || ws_op[0]);
    e_mask  = ws_op[1] ? ws_rj_value : 32'hFFFF_FFFF;
    e_old   = csr_mem[ws_csr_num[5:0]];
    e_flush = !e_run || e_exc || e_ertn;

    if (m_known) begin
      chk("wb_ex", 32'(wb_ex), 32'(e_exc));
      chk("ertn_flush", 32'(ertn_flush), 32'(e_ertn));
      chk("csr_re", 32'(csr_re), 32'(e_re));
      chk("csr_we", 32'(csr_we), 32'(e_we));
      chk("csr_num", 32'(csr_num), 32'(ws_csr_num));
      chk("ws_rf_wdata", ws_rf_wdata, e_old);
      chk("ws_commit", 32'(ws_commit), 32'(e_take && !e_exc));
      chk("wb_csr_pc", wb_csr_pc, ws_pc);
      chk("flush_o", 32'(flush_o), 32'(e_flush));
      chk("redir_valid", 32'(redir_valid), 32'(m_pend));
      chk("redir_pc", redir_pc, m_pc);
      if (e_we) begin
        chk("csr_wmask", csr_wmask, e_mask);
        chk("csr_wvalue", csr_wvalue, ws_rd_value);
      end
      if (e_exc) begin
        chk("wb_ecode", 32'(wb_ecode), 32'(e_code));
        chk("wb_esubcode", 32'(wb_esubcode), 32'h0);
        chk("wb_vaddr", wb_vaddr, e_badv ? ws_badv : 32'h0);
      end
    end

    wr_pend <= resetn && e_we;
    wr_addr <= ws_csr_num[5:0];
    wr_data <= (e_old & ~e_mask) | (ws_rd_value & e_mask);

    if (!resetn) begin
      m_known = 1'b1;
      m_pend  = 1'b0;
      m_hold  = 0;
      m_pc    = 32'h0;
    end else if (e_exc || e_ertn) begin
      m_pend = 1'b1;
      m_pc   = e_exc ? ex_entry : ertn_entry;
    end else if (m_pend && redir_ready) begin
      m_pend = 1'b0;
      m_hold = FH;
    end else if (m_hold > 0) begin
      m_hold = m_hold - 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic nop();
    ws_valid    = 1'b0;
    ws_op       = 3'b000;
    ws_csr_rd   = 1'b0;
    ws_ex_flags = 5'b0;
    has_int     = 1'b0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [2:0] op, input logic rd,
                       input logic [13:0] num, input logic [31:0] rj, input logic [31:0] rdv,
                       input logic [4:0] fl, input logic [31:0] badv, input logic intr);
    ws_valid    = 1'b1;
    ws_pc       = pc;
    ws_op       = op;
    ws_csr_rd   = rd;
    ws_csr_num  = num;
    ws_rj_value = rj;
    ws_rd_value = rdv;
    ws_ex_flags = fl;
    ws_badv     = badv;
    has_int     = intr;
  endtask

  // Accept the redirect in the next cycle, then ride out the hold cycles.
  task automatic drain();
    tick(); nop(); redir_ready = 1'b1;
    tick(); redir_ready = 1'b0;
    repeat (FH - 1) tick();
  endtask

  logic [4:0]  pv_flags [6];
  logic        pv_int   [6];
  logic [5:0]  pv_code  [6];
  logic        pv_badv  [6];

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    pv_flags[0] = 5'b11111; pv_int[0] = 1'b0; pv_code[0] = 6'h08; pv_badv[0] = 1'b1;
    pv_flags[1] = 5'b11110; pv_int[1] = 1'b0; pv_code[1] = 6'h0D; pv_badv[1] = 1'b0;
    pv_flags[2] = 5'b11100; pv_int[2] = 1'b0; pv_code[2] = 6'h0B; pv_badv[2] = 1'b0;
    pv_flags[3] = 5'b11000; pv_int[3] = 1'b0; pv_code[3] = 6'h0C; pv_badv[3] = 1'b0;
    pv_flags[4] = 5'b10000; pv_int[4] = 1'b0; pv_code[4] = 6'h09; pv_badv[4] = 1'b1;
    pv_flags[5] = 5'b00001; pv_int[5] = 1'b1; pv_code[5] = 6'h00; pv_badv[5] = 1'b0;

    resetn = 1'b0; redir_ready = 1'b0; ex_entry = '0; ertn_entry = '0;
    ws_pc = '0; ws_csr_num = '0; ws_rj_value = '0; ws_rd_value = '0; ws_badv = '0;
    nop();
    tick(); tick(); resetn = 1'b1;
    look();
    chk("reset redir_valid", 32'(redir_valid), 32'h0);
    chk("reset redir_pc", redir_pc, 32'h0);
    chk("reset flush_o", 32'(flush_o), 32'h0);

    // csrwr CRMD
    tick(); issue(32'h1C00_0000, 3'b001, 1'b1, CSR_CRMD, 32'h0, 32'h4, 5'b0, 32'h0, 1'b0);
    look();
    chk("csrwr csr_we", 32'(csr_we), 32'h1);
    chk("csrwr wmask", csr_wmask, 32'hFFFF_FFFF);
    chk("csrwr old CRMD", ws_rf_wdata, 32'h0000_0008);
    chk("csrwr commit", 32'(ws_commit), 32'h1);
    chk("csrwr flush", 32'(flush_o), 32'h0);

    // csrxchg SAVE0
    tick(); issue(32'h1C00_0004, 3'b010, 1'b1, CSR_SAVE0, 32'h0000_00FF, 32'h1234_5678, 5'b0, 32'h0, 1'b0);
    look();
    chk("xchg wmask", csr_wmask, 32'h0000_00FF);
    chk("xchg wvalue", csr_wvalue, 32'h1234_5678);
    chk("xchg old SAVE0", ws_rf_wdata, 32'hAAAA_5555);

    // csrrd sees both masked write and the earlier CRMD write
    tick(); issue(32'h1C00_0008, 3'b000, 1'b1, CSR_SAVE0, 32'h0, 32'h0, 5'b0, 32'h0, 1'b0);
    look();
    chk("csrrd SAVE0 merged", ws_rf_wdata, 32'hAAAA_5578);
    chk("csrrd csr_we", 32'(csr_we), 32'h0);
    tick(); issue(32'h1C00_000C, 3'b000, 1'b1, CSR_CRMD, 32'h0, 32'h0, 5'b0, 32'h0, 1'b0);
    look();
    chk("csrrd CRMD", ws_rf_wdata, 32'h0000_0004);

    // syscall, redirect held off by fetch for 3 cycles
    tick(); ex_entry = 32'h1C00_8000;
    issue(32'h1C00_0100, 3'b000, 1'b0, 14'h0, 32'h0, 32'h0, 5'b00100, 32'h0, 1'b0);
    look();
    chk("sys wb_ex", 32'(wb_ex), 32'h1);
    chk("sys ecode", 32'(wb_ecode), 32'h0B);
    chk("sys flush", 32'(flush_o), 32'h1);
    chk("sys era", wb_csr_pc, 32'h1C00_0100);
    for (int i = 0; i < 3; i++) begin
      tick(); nop(); ex_entry = 32'hDEAD_0000;
      look();
      chk("stall redir_valid", 32'(redir_valid), 32'h1);
      chk("stall redir_pc", redir_pc, 32'h1C00_8000);
    end
    tick(); redir_ready = 1'b1;
    look();
    chk("handshake redir_valid", 32'(redir_valid), 32'h1);

    // csrwr with sys+ale+int arrives during HOLD: deferred, then taken as INT
    for (int i = 0; i < FH; i++) begin
      tick(); redir_ready = 1'b0;
      issue(32'h1C00_0200, 3'b001, 1'b1, CSR_CRMD, 32'h0, 32'h77, 5'b10100, 32'hBAD0_0001, 1'b1);
      look();
      chk("hold wb_ex", 32'(wb_ex), 32'h0);
      chk("hold flush", 32'(flush_o), 32'h1);
    end
    tick(); ex_entry = 32'h1C00_8000;
    look();
    chk("int wb_ex", 32'(wb_ex), 32'h1);
    chk("int ecode", 32'(wb_ecode), 32'h00);
    chk("int csr_we", 32'(csr_we), 32'h0);
    chk("int vaddr", wb_vaddr, 32'h0);
    drain();

    // ertn
    tick(); ertn_entry = 32'h1C00_0104;
    issue(32'h1C00_0300, 3'b100, 1'b0, 14'h0, 32'h0, 32'h0, 5'b0, 32'h0, 1'b0);
    look();
    chk("ertn flush pulse", 32'(ertn_flush), 32'h1);
    chk("ertn wb_ex", 32'(wb_ex), 32'h0);
    tick(); nop(); redir_ready = 1'b1; ertn_entry = 32'h0;
    look();
    chk("ertn redir_pc", redir_pc, 32'h1C00_0104);
    tick(); redir_ready = 1'b0;
    look();
    chk("ertn hold1 flush", 32'(flush_o), 32'h1);
    tick();
    look();
    chk("ertn hold2 flush", 32'(flush_o), 32'h1);
    tick();
    look();
    chk("ertn after hold flush", 32'(flush_o), 32'h0);

    // priority table
    for (int i = 0; i < 6; i++) begin
      tick(); ex_entry = 32'h1C00_8000 + 32'(i);
      issue(32'h1C00_0400 + 32'(4 * i), 3'b000, 1'b0, 14'h0, 32'h0, 32'h0,
            pv_flags[i], 32'hBAD0_0000 + 32'(i), pv_int[i]);
      look();
      chk("prio ecode", 32'(wb_ecode), 32'(pv_code[i]));
      chk("prio vaddr", wb_vaddr, pv_badv[i] ? 32'hBAD0_0000 + 32'(i) : 32'h0);
      drain();
    end

    // reset while REDIR aborts the redirect
    tick(); ex_entry = 32'h1C00_9000;
    issue(32'h1C00_0500, 3'b000, 1'b0, 14'h0, 32'h0, 32'h0, 5'b01000, 32'h0, 1'b0);
    look();
    chk("brk ecode", 32'(wb_ecode), 32'h0C);
    tick(); resetn = 1'b0;
    issue(32'h1C00_0504, 3'b001, 1'b1, CSR_CRMD, 32'h0, 32'h99, 5'b0, 32'h0, 1'b0);
    look();
    chk("redir csrwr blocked", 32'(csr_we), 32'h0);
    chk("redir before reset", 32'(redir_valid), 32'h1);
    tick(); resetn = 1'b1; nop();
    look();
    chk("post-reset redir_valid", 32'(redir_valid), 32'h0);
    chk("post-reset flush", 32'(flush_o), 32'h0);
    tick(); issue(32'h1C00_0600, 3'b001, 1'b1, CSR_SAVE0, 32'h0, 32'h5, 5'b0, 32'h0, 1'b0);
    look();
    chk("post-reset csr_we", 32'(csr_we), 32'h1);
    tick(); nop();
    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
